// File: rtl/bit_pattern_pkg.sv
// bit_pattern_pkg: shared types and helpers for the serial bit-pattern transmitter.
//   tx_state_t  - transmitter FSM state encoding
//   IDLE_LEVEL  - level driven on d_out when no frame bit is on the line
//   even_parity - XOR reduction of a word (zero-extend narrower words to 32 bits)
package bit_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } tx_state_t;

    localparam logic IDLE_LEVEL = 1'b0;

    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/bit_pattern_tx_bit_timer.sv
// bit_timer: bit-period timer for the serial transmitter.
//   Parameter BIT_CYCLES (1..255): clock cycles per bit.
//   clk   in  rising-edge clock
//   reset in  synchronous active-high reset
//   run   in  count while high; counter held at 0 while low
//   tick  out high in the last cycle of each bit period
module bit_timer #(
    parameter int BIT_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign tick = run && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bit_pattern_tx.sv
// bit_pattern_tx: parallel-in, MSB-first serial transmitter with per-bit hold time.
//   Parameters: WIDTH (1..32) data bits per frame, BIT_CYCLES (1..255) cycles per bit.
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   data_in    in   word to send, captured on accept
//   load_valid in   source offers a word
//   load_ready out  high only in IDLE
//   d_out      out  serial line, IDLE_LEVEL when no frame bit is driven
//   d_valid    out  d_out carries a frame bit
//   busy       out  frame in progress (SHIFT, PARITY, GAP)
//   done       out  one-cycle pulse in the GAP cycle after the last bit
// Build option: define BIT_PATTERN_TX_PARITY_EN to append one even-parity bit
// after the data bits.
module bit_pattern_tx
    import bit_pattern_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             d_out,
    output logic             d_valid,
    output logic             busy,
    output logic             done
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             run, tick;
`ifdef BIT_PATTERN_TX_PARITY_EN
    // Parity is taken from the word at capture time since the shift register
    // is consumed as the frame goes out.
    logic             par_q, par_d;
`endif

    assign run = (state_q == SHIFT) || (state_q == PARITY);

    bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
`ifdef BIT_PATTERN_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    shreg_d   = data_in;
                    bit_cnt_d = '0;
`ifdef BIT_PATTERN_TX_PARITY_EN
                    par_d     = even_parity(32'(data_in));
`endif
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef BIT_PATTERN_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = GAP;
`endif
                    end
                end
            end
`ifdef BIT_PATTERN_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = GAP;
                end
            end
`endif
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
`ifdef BIT_PATTERN_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef BIT_PATTERN_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    // Outputs decode registered state only; no input reaches an output.
    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == GAP);
    assign d_valid    = run;

    always_comb begin
        d_out = IDLE_LEVEL;
        case (state_q)
            SHIFT:   d_out = shreg_q[WIDTH-1];
`ifdef BIT_PATTERN_TX_PARITY_EN
            PARITY:  d_out = par_q;
`endif
            default: d_out = IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_bit_pattern_tx.sv
module tb_bit_pattern_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din_a, din_b;
    logic       lv_a, lv_b;
    logic       rdy_a, dout_a, dv_a, busy_a, done_a;
    logic       rdy_b, dout_b, dv_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_pattern_tx #(.WIDTH(8), .BIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .data_in(din_a), .load_valid(lv_a),
        .load_ready(rdy_a), .d_out(dout_a), .d_valid(dv_a), .busy(busy_a), .done(done_a)
    );

    bit_pattern_tx #(.WIDTH(8), .BIT_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .data_in(din_b), .load_valid(lv_b),
        .load_ready(rdy_b), .d_out(dout_b), .d_valid(dv_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        logic       rst;
        logic       lv;
        logic [7:0] data;
        logic       dout, dv, bsy, dn, rdy;
        string      tag;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic lv, input logic [7:0] data,
                                input logic dout, input logic dv, input logic bsy,
                                input logic dn, input logic rdy, input string tag);
        vec_t v;
        v.rst = rst; v.lv = lv; v.data = data;
        v.dout = dout; v.dv = dv; v.bsy = bsy; v.dn = dn; v.rdy = rdy; v.tag = tag;
        return v;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_a(input string name, input logic dout, input logic dv,
                         input logic bsy, input logic dn, input logic rdy);
        chk({name, ".d_out"},      dout_a, dout);
        chk({name, ".d_valid"},    dv_a,   dv);
        chk({name, ".busy"},       busy_a, bsy);
        chk({name, ".done"},       done_a, dn);
        chk({name, ".load_ready"}, rdy_a,  rdy);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic pat_a5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic pat_07 [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        reset = 1'b1; lv_a = 1'b0; lv_b = 1'b0; din_a = 8'h00; din_b = 8'h00;

        // ---- table: reset, idle, clean 0xA5 frame, 0xA5 frame with noisy load_valid ----
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 1, "reset"));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, "idle"));
        for (int k = 0; k < 16; k++)
            tbl.push_back(mk(0, (k == 0), 8'hA5, pat_a5[k/2], 1, 1, 0, 0, "a5_bit"));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 0, "a5_gap"));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, "a5_idle"));
        // Second frame: accept 0xA5, then load_valid toggles with 0x3C during SHIFT.
        for (int k = 0; k < 16; k++)
            tbl.push_back(mk(0, (k == 0) ? 1'b1 : logic'(k % 2), (k == 0) ? 8'hA5 : 8'h3C,
                             pat_a5[k/2], 1, 1, 0, 0, "ign_bit"));
        tbl.push_back(mk(0, 1, 8'h3C, 0, 0, 1, 1, 0, "ign_gap"));
        tbl.push_back(mk(0, 1, 8'h3C, 0, 0, 0, 0, 1, "ign_idle"));  // offered in GAP: dropped
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, "ign_after"));

        foreach (tbl[i]) begin
            reset = tbl[i].rst; lv_a = tbl[i].lv; din_a = tbl[i].data;
            step();
            chk_a($sformatf("%s[%0d]", tbl[i].tag, i),
                  tbl[i].dout, tbl[i].dv, tbl[i].bsy, tbl[i].dn, tbl[i].rdy);
        end
        lv_a = 1'b0;

        // ---- reset at bit 4 of 0xA5: abort, then 20 quiet cycles, no done ----
        lv_a = 1'b1; din_a = 8'hA5;
        step();
        lv_a = 1'b0;
        for (int k = 1; k <= 8; k++) step();
        chk_a("bit4_before_reset", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        chk_a("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            chk_a($sformatf("quiet[%0d]", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // ---- reset and load_valid together: reset wins ----
        reset = 1'b1; lv_a = 1'b1; din_a = 8'hFF;
        step();
        chk_a("rst_lv", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0; lv_a = 1'b0;
        step();
        chk_a("rst_lv_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // ---- 0x07 frame on dut_a, with or without the parity bit ----
        lv_a = 1'b1; din_a = 8'h07;
`ifdef BIT_PATTERN_TX_PARITY_EN
        for (int k = 0; k < 18; k++) begin
            step();
            lv_a = 1'b0;
            chk($sformatf("par07_dout[%0d]", k), dout_a, pat_07[k/2]);
            chk($sformatf("par07_dv[%0d]", k), dv_a, 1'b1);
        end
        step();
        chk_a("par07_gap", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
`else
        for (int k = 0; k < 16; k++) begin
            step();
            lv_a = 1'b0;
            chk($sformatf("f07_dout[%0d]", k), dout_a, pat_07[k/2]);
            chk($sformatf("f07_dv[%0d]", k), dv_a, 1'b1);
        end
        step();
        chk_a("f07_gap", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
`endif
        step();
        chk_a("f07_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // ---- dut_b, BIT_CYCLES=1: 0xFF then 0x00 back-to-back, load_valid held ----
        chk("b_idle_ready", rdy_b, 1'b1);
        lv_b = 1'b1; din_b = 8'hFF;
        step();
        din_b = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            chk($sformatf("bff_dout[%0d]", k), dout_b, 1'b1);
            chk($sformatf("bff_dv[%0d]", k), dv_b, 1'b1);
        end
        step();
        chk("bff_gap_done", done_b, 1'b1);
        chk("bff_gap_dout", dout_b, 1'b0);
        chk("bff_gap_ready", rdy_b, 1'b0);
        step();
        chk("b_ready_back", rdy_b, 1'b1);
        chk("b_ready_busy", busy_b, 1'b0);
        step();  // accepted exactly at the first load_ready
        lv_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            chk($sformatf("b00_dout[%0d]", k), dout_b, 1'b0);
            chk($sformatf("b00_dv[%0d]", k), dv_b, 1'b1);
            chk($sformatf("b00_ready[%0d]", k), rdy_b, 1'b0);
        end
        step();
        chk("b00_gap_done", done_b, 1'b1);
        step();
        chk("b00_idle_ready", rdy_b, 1'b1);
        chk("b00_idle_done", done_b, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_pattern_tx.md
# bit_pattern_tx

Serial bit-pattern transmitter: accepts a parallel word over a valid/ready handshake and drives it MSB-first onto a single-bit serial line. Each bit is held for a programmable number of clock cycles. It is the driving end of the single-bit `d` input consumed by the team's flip-flop and register blocks, and replaces hand-written stimulus sequences with a synthesizable source. Downstream capture logic samples `d_out` while `d_valid` is high.

## Interface
- `WIDTH`, default 8: data bits per frame; legal range 1..32.
- `BIT_CYCLES`, default 2: clock cycles each bit is held; legal range 1..255.

- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  WIDTH  word to transmit; sampled only on an accepted load.
- `load_valid`  in  1  source has a word on `data_in`.
- `load_ready`  out  1  block can accept a word; high only in IDLE.
- `d_out`  out  1  serial data line; idle level 0.
- `d_valid`  out  1  high while `d_out` carries a frame bit.
- `busy`  out  1  high from the cycle after accept until the end of GAP.
- `done`  out  1  one-cycle pulse at frame completion.

## Operation
- FSM states: IDLE, SHIFT, (PARITY), GAP.
- IDLE
  - `load_ready`=1; all other outputs are 0.
  - On `load_valid && load_ready`: capture `data_in` into the shift register, clear the bit counter, and go to SHIFT.
- SHIFT
  - `d_out` = shift register MSB; `d_valid`=1; `busy`=1.
  - The bit timer counts 0..BIT_CYCLES-1.
  - On the terminal count: shift left by 1 and increment the bit counter.
  - After bit WIDTH-1 completes, go to PARITY if the parity feature is compiled in, otherwise go to GAP.
- PARITY
  - `d_out` = even parity (XOR) of the captured word; `d_valid`=1.
  - Held for BIT_CYCLES cycles, then go to GAP.
- GAP
  - Lasts exactly 1 cycle: `d_out`=0, `d_valid`=0, `busy`=1, `done`=1.
  - Then go to IDLE.
- `load_valid` outside IDLE is ignored; no word is queued.
- The bit counter is $clog2(WIDTH+1) bits wide. The bit timer is 8 bits wide and wraps to 0 on its terminal count.
- `BIT_CYCLES`=1 gives one bit per clock.
- All outputs are registered or decoded directly from registered state; there is no combinational path from input to output.

## Timing
- Reset values: state=IDLE, `load_ready`=1, `d_out`=0, `d_valid`=0, `busy`=0, `done`=0, and all counters 0.
- Accept occurs at edge N. Bit 0 (the MSB) appears on `d_out` from N+1 and is held for BIT_CYCLES cycles.
- Frame length is WIDTH×BIT_CYCLES cycles, plus BIT_CYCLES when parity is compiled in.
- `done` is high in the cycle immediately after the last bit period.
- `load_ready` returns to 1 in the cycle after `done`. The earliest back-to-back accept is that cycle.
- `reset` asserted mid-frame: at the next edge, all outputs take their reset values and the frame is aborted with no `done` pulse.
- `reset` and `load_valid` high together: reset wins and the word is not accepted.

## Configuration
- `BIT_PATTERN_TX_PARITY_EN`
  - Defined: the PARITY state exists, and one even-parity bit is appended after the data bits, held BIT_CYCLES cycles with `d_valid`=1.
  - Undefined: the PARITY state and its logic are absent, and the frame is data bits only.

## Structure
- `bit_pattern_pkg` holds:
  - the state enum `tx_state_t` (IDLE, SHIFT, PARITY, GAP);
  - the constant `IDLE_LEVEL` = 1'b0;
  - the function `even_parity(word)`.
- Sub-module `bit_timer`:
  - parameter BIT_CYCLES; inputs `clk`, `reset`, `run`; output `tick`;
  - `tick` is high in the last cycle of each bit period;
  - counter is cleared when `run`=0.

## Test plan
- Single frame (WIDTH=8, BIT_CYCLES=2, `data_in`=0xA5 accepted at edge N) -> `d_out` is 1,0,1,0,0,1,0,1, each bit 2 cycles, over N+1..N+16; `done` at N+17; `load_ready` at N+18.
- BIT_CYCLES=1, `data_in`=0xFF, then 0x00 offered back-to-back -> 8 cycles of 1, GAP, then 8 cycles of 0; the second accept occurs exactly at the first `load_ready`.
- `load_valid` toggled during SHIFT with `data_in`=0x3C -> ignored; `d_out` pattern unchanged; `load_ready` stays 0.
- `reset` pulsed at bit 4 of 0xA5 -> next cycle `d_out`=0, `d_valid`=0, `busy`=0, `load_ready`=1; no `done` pulse.
- PARITY_EN defined, `data_in`=0x07 -> bits 0,0,0,0,0,1,1,1 followed by parity bit 1; `done` arrives 18 cycles after N+1 at BIT_CYCLES=2.
- After reset with no load for 20 cycles -> `d_out`=0, `d_valid`=0, `busy`=0, `done`=0 held throughout.
